// File: rtl/fft_pkg.sv
// Shared types and helpers for the iterative radix-2 FFT core: FSM encoding,
// default fixed-point widths, index bit reversal and output saturation.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  localparam int Q_IN_DEF   = 15;
  localparam int Q_DATA_DEF = 15;
  localparam int Q_OUT_DEF  = 15;

  // Largest supported transform is 512 points.
  localparam int MAX_LOG2N = 9;

  function automatic logic [MAX_LOG2N-1:0] bit_rev(input logic [MAX_LOG2N-1:0] v,
                                                    input int bits);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      if (i < bits) r[bits-1-i] = v[i];
    end
    return r;
  endfunction

  // Clamp a signed value to the range of a (q+1)-bit two's-complement word.
  function automatic logic signed [31:0] sat_q(input logic signed [31:0] v, input int q);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< q) - 32'sd1;
    lo = -(32'sd1 <<< q);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle table W_k = exp(-j*2*pi*k/N), k = 0..N/2-1, built at elaboration with
// +1.0 coded as 2^Q_DATA-1; registered read with one cycle of latency.
module fft_twiddle_rom #(
  parameter int N      = 8,
  parameter int Q_DATA = 15,
  localparam int KW    = $clog2(N) - 1
) (
  input  logic          clk,
  input  logic [KW-1:0] k,
  output logic [Q_DATA:0] w_re,
  output logic [Q_DATA:0] w_im
);

  localparam real PI   = 3.14159265358979323846;
  localparam real FULL = 2.0 ** Q_DATA - 1.0;

  logic [Q_DATA:0] tab_re [N/2];
  logic [Q_DATA:0] tab_im [N/2];

  for (genvar i = 0; i < N/2; i++) begin : g_tab
    localparam real C  = FULL * $cos(2.0 * PI * i / N);
    localparam real S  = -FULL * $sin(2.0 * PI * i / N);
    localparam int  CI = (C >= 0.0) ? $rtoi(C + 0.5) : -$rtoi(0.5 - C);
    localparam int  SI = (S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(0.5 - S);
    assign tab_re[i] = (Q_DATA+1)'(CI);
    assign tab_im[i] = (Q_DATA+1)'(SI);
  end

  // NOTE: pure storage/read registers carry no reset; their contents are
  // always rewritten before use, and omitting it lets them map onto RAM/ROM.
  always_ff @(posedge clk) begin
    w_re <= tab_re[k];
    w_im <= tab_im[k];
  end

endmodule

// File: rtl/fft_radix2_iter.sv
// Iterative N-point radix-2 DIT FFT: serial real load in bit-reversed order,
// LOG2N in-place passes through one 2-cycle butterfly, natural-order output.
module fft_radix2_iter
  import fft_pkg::*;
#(
  parameter int N      = 8,
  parameter int LOG2N  = 3,
  parameter int Q_IN   = Q_IN_DEF,
  parameter int Q_DATA = Q_DATA_DEF,
  parameter int Q_OUT  = Q_OUT_DEF,
  parameter int SCALE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [Q_IN:0]    data_in,
  output logic             ready_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [LOG2N-1:0] addr_out,
  output logic [Q_OUT:0]   data_out_real,
  output logic [Q_OUT:0]   data_out_imag,
  output logic             last_out
);

  localparam int PW = Q_OUT + Q_DATA + 3;
  localparam int GW = Q_OUT + 3;
  localparam logic signed [PW-1:0] RND       = PW'(2 ** (Q_DATA - 1));
  localparam logic [LOG2N-1:0]     CNT_LAST  = '1;
  localparam logic [LOG2N-2:0]     J_LAST    = '1;
  localparam logic [3:0]           PASS_LAST = 4'(LOG2N - 1);

  state_t state, state_next;

  logic [LOG2N-1:0] cnt;
  logic [3:0]       pass;
  logic [LOG2N-2:0] bf_j;
  logic             phase;

  logic signed [Q_OUT:0] mem_re [N];
  logic signed [Q_OUT:0] mem_im [N];

  logic signed [Q_OUT:0]  a_re, a_im, b_re, b_im;
  logic signed [Q_DATA:0] w_re, w_im;

  logic             accept_in, out_fire, bf_we;
  logic [LOG2N-1:0] load_addr, next_addr;
  logic [LOG2N-1:0] j_ext, half, mask, addr_a, addr_b;
  logic [LOG2N-2:0] tw_k;

  logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
  logic signed [GW-1:0]  t_re, t_im, s0_re, s0_im, s1_re, s1_im;
  logic signed [Q_OUT:0] y0_re, y0_im, y1_re, y1_im;

  assign ready_in  = (state == IDLE) || (state == LOAD);
  assign accept_in = valid_in && ready_in;
  assign out_fire  = valid_out && ready_out;
  assign bf_we     = (state == COMPUTE) && phase;
  assign load_addr = LOG2N'(bit_rev(MAX_LOG2N'(cnt), LOG2N));
  assign next_addr = addr_out + LOG2N'(1);

  // Butterfly addressing: pairs are 2^pass apart; counters hold still across
  // the read and write cycles, so these addresses serve both.
  always_comb begin
    j_ext  = {1'b0, bf_j};
    half   = LOG2N'(1) << pass;
    mask   = half - LOG2N'(1);
    addr_a = ((j_ext >> pass) << (pass + 4'd1)) | (j_ext & mask);
    addr_b = addr_a | half;
    tw_k   = (bf_j & mask[LOG2N-2:0]) << (LOG2N - 1 - int'(pass));
  end

  fft_twiddle_rom #(.N(N), .Q_DATA(Q_DATA)) u_twiddle_rom (
    .clk (clk),
    .k   (tw_k),
    .w_re(w_re),
    .w_im(w_im)
  );

  always_comb begin
    p_rr  = PW'(b_re) * PW'(w_re);
    p_ii  = PW'(b_im) * PW'(w_im);
    p_ri  = PW'(b_re) * PW'(w_im);
    p_ir  = PW'(b_im) * PW'(w_re);
    t_re  = GW'(((p_rr + RND) >>> Q_DATA) - ((p_ii + RND) >>> Q_DATA));
    t_im  = GW'(((p_ri + RND) >>> Q_DATA) + ((p_ir + RND) >>> Q_DATA));
    s0_re = GW'(a_re) + t_re;
    s0_im = GW'(a_im) + t_im;
    s1_re = GW'(a_re) - t_re;
    s1_im = GW'(a_im) - t_im;
    if (SCALE != 0) begin
      s0_re = s0_re >>> 1;
      s0_im = s0_im >>> 1;
      s1_re = s1_re >>> 1;
      s1_im = s1_im >>> 1;
    end
    y0_re = (Q_OUT+1)'(sat_q(32'(s0_re), Q_OUT));
    y0_im = (Q_OUT+1)'(sat_q(32'(s0_im), Q_OUT));
    y1_re = (Q_OUT+1)'(sat_q(32'(s1_re), Q_OUT));
    y1_im = (Q_OUT+1)'(sat_q(32'(s1_im), Q_OUT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first guarantees every path drives
  // state_next, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept_in) state_next = LOAD;
      LOAD:    if (accept_in && cnt == CNT_LAST) state_next = COMPUTE;
      COMPUTE: if (phase && bf_j == J_LAST && pass == PASS_LAST) state_next = OUTPUT;
      OUTPUT:  if (out_fire && addr_out == CNT_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      pass          <= '0;
      bf_j          <= '0;
      phase         <= 1'b0;
      a_re          <= '0;
      a_im          <= '0;
      b_re          <= '0;
      b_im          <= '0;
      valid_out     <= 1'b0;
      addr_out      <= '0;
      data_out_real <= '0;
      data_out_imag <= '0;
      last_out      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, LOAD: if (accept_in) cnt <= cnt + LOG2N'(1);
        COMPUTE: begin
          phase <= ~phase;
          if (!phase) begin
            a_re <= mem_re[addr_a];
            a_im <= mem_im[addr_a];
            b_re <= mem_re[addr_b];
            b_im <= mem_im[addr_b];
          end else begin
            bf_j <= bf_j + (LOG2N-1)'(1);
            if (bf_j == J_LAST) pass <= (pass == PASS_LAST) ? 4'd0 : pass + 4'd1;
          end
        end
        OUTPUT: begin
          // One idle cycle before bin 0 gives the fixed N*LOG2N+2 latency.
          if (!valid_out) begin
            phase <= ~phase;
            if (phase) begin
              valid_out     <= 1'b1;
              addr_out      <= '0;
              data_out_real <= mem_re[0];
              data_out_imag <= mem_im[0];
            end
          end else if (ready_out) begin
            if (addr_out == CNT_LAST) begin
              valid_out <= 1'b0;
              last_out  <= 1'b0;
              addr_out  <= '0;
            end else begin
              addr_out      <= next_addr;
              data_out_real <= mem_re[next_addr];
              data_out_imag <= mem_im[next_addr];
              last_out      <= (next_addr == CNT_LAST);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept_in) begin
      mem_re[load_addr] <= (Q_OUT+1)'($signed(data_in));
      mem_im[load_addr] <= '0;
    end else if (bf_we) begin
      mem_re[addr_a] <= y0_re;
      mem_im[addr_a] <= y0_im;
      mem_re[addr_b] <= y1_re;
      mem_im[addr_b] <= y1_im;
    end
  end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Bench for fft_radix2_iter: an 8-point unscaled and a 64-point scaled core are
// checked against a floating-point DFT reference with directed and random frames.
module tb_fft_radix2_iter;

  localparam real PI  = 3.14159265358979323846;
  localparam int  TOL = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        sel       = 1'b0;
  logic        valid_in  = 1'b0;
  logic        ready_out = 1'b0;
  logic [15:0] data_in   = '0;

  logic        ri_a, vo_a, lo_a, ri_b, vo_b, lo_b;
  logic [2:0]  ad_a;
  logic [5:0]  ad_b;
  logic [15:0] re_a, im_a, re_b, im_b;

  logic        ri, vo, lo;
  logic [5:0]  ad;
  logic [15:0] re, im;

  assign ri = sel ? ri_b : ri_a;
  assign vo = sel ? vo_b : vo_a;
  assign lo = sel ? lo_b : lo_a;
  assign ad = sel ? ad_b : {3'b000, ad_a};
  assign re = sel ? re_b : re_a;
  assign im = sel ? im_b : im_a;

  int n_checks = 0;
  int n_fail   = 0;
  int x     [64];
  int ex_re [64];
  int ex_im [64];

  always #5 clk = ~clk;

  fft_radix2_iter #(.N(8), .LOG2N(3), .SCALE(0)) dut_a (
    .clk(clk), .reset(reset), .valid_in(valid_in & ~sel), .data_in(data_in),
    .ready_in(ri_a), .valid_out(vo_a), .ready_out(ready_out), .addr_out(ad_a),
    .data_out_real(re_a), .data_out_imag(im_a), .last_out(lo_a)
  );

  fft_radix2_iter #(.N(64), .LOG2N(6), .SCALE(1)) dut_b (
    .clk(clk), .reset(reset), .valid_in(valid_in & sel), .data_in(data_in),
    .ready_in(ri_b), .valid_out(vo_b), .ready_out(ready_out), .addr_out(ad_b),
    .data_out_real(re_b), .data_out_imag(im_b), .last_out(lo_b)
  );

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    int d;
    n_checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Direct DFT of x[0..n-1], optionally divided by n, clipped to the output word.
  task automatic model(input int n, input bit scale);
    for (int k = 0; k < n; k++) begin
      real sr, si, ang;
      sr = 0.0;
      si = 0.0;
      for (int i = 0; i < n; i++) begin
        ang = 2.0 * PI * real'((k * i) % n) / real'(n);
        sr += real'(x[i]) * $cos(ang);
        si -= real'(x[i]) * $sin(ang);
      end
      if (scale) begin
        sr = sr / real'(n);
        si = si / real'(n);
      end
      ex_re[k] = clamp16(rnd(sr));
      ex_im[k] = clamp16(rnd(si));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready_in"},  int'(ri), 1);
    check({tag, "_valid_out"}, int'(vo), 0);
    check({tag, "_addr_out"},  int'(ad), 0);
    check({tag, "_real"},      int'(re), 0);
    check({tag, "_imag"},      int'(im), 0);
    check({tag, "_last_out"},  int'(lo), 0);
  endtask

  task automatic load_frame(input int n);
    int c = 0;
    int guard = 0;
    bit acc;
    while (c < n && guard < 4 * n + 20) begin
      valid_in = ($urandom_range(3) != 0);
      data_in  = 16'(x[c]);
      acc      = valid_in && ri;
      step();
      guard++;
      if (acc) c++;
    end
    valid_in = 1'b0;
    check("load_samples", c, n);
  endtask

  // Counts edges from the last accepted sample to the first valid bin, while
  // throwing ignored valid_in pulses at the busy core.
  task automatic wait_first(input int n, input int lg);
    int lat = 0;
    while (!vo && lat < n * lg + 10) begin
      valid_in = ($urandom_range(1) == 1);
      data_in  = 16'($urandom);
      if (lat == 0 || lat == n) check("ready_in_busy", int'(ri), 0);
      step();
      lat++;
    end
    valid_in = 1'b0;
    check("first_valid_latency", lat, n * lg + 2);
  endtask

  // Every cycle with valid_out high is compared to the bin currently owed,
  // so stalled cycles must hold the same bin.
  task automatic collect(input int n, input int nb, input bit stall);
    int k = 0;
    int guard = 0;
    while (k < nb && guard < 8 * n + 20) begin
      if (!vo) begin
        check("valid_out_in_stream", int'(vo), 1);
        break;
      end
      check($sformatf("addr[%0d]", k), int'(ad), k);
      check($sformatf("last[%0d]", k), int'(lo), int'(k == n - 1));
      check($sformatf("real[%0d]", k), int'($signed(re)), ex_re[k], TOL);
      check($sformatf("imag[%0d]", k), int'($signed(im)), ex_im[k], TOL);
      ready_out = stall ? ($urandom_range(1) == 1) : 1'b1;
      if (ready_out) k++;
      step();
      guard++;
    end
    ready_out = 1'b0;
    check("bins_accepted", k, nb);
    if (nb == n) begin
      check("done_valid_out", int'(vo), 0);
      check("done_last_out",  int'(lo), 0);
      check("done_ready_in",  int'(ri), 1);
    end
  endtask

  task automatic run(input bit stall);
    int n  = sel ? 64 : 8;
    int lg = sel ? 6 : 3;
    model(n, sel);
    load_frame(n);
    wait_first(n, lg);
    collect(n, n, stall);
  endtask

  task automatic fill_random(input int n, input int amp);
    for (int i = 0; i < n; i++) x[i] = int'($urandom_range(2 * amp)) - amp;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1 check_reset_vals("reset");
    repeat (3) step();
    reset = 1'b0;
    step();

    // 8-point, unscaled
    sel = 1'b0;
    for (int i = 0; i < 8; i++) x[i] = (i == 0) ? 1000 : 0;
    run(1'b0);
    for (int i = 0; i < 8; i++) x[i] = 1000;
    run(1'b0);
    for (int i = 0; i < 8; i++) x[i] = (i % 2 == 0) ? 1000 : -1000;
    run(1'b0);
    for (int i = 0; i < 8; i++) x[i] = 32767;
    run(1'b0);
    for (int r = 0; r < 3; r++) begin
      fill_random(8, 4000);
      run(r != 0);
    end

    // 64-point, scaled by 1/N
    sel = 1'b1;
    for (int i = 0; i < 64; i++) x[i] = 1000;
    run(1'b0);
    for (int i = 0; i < 64; i++) x[i] = rnd(16384.0 * $cos(2.0 * PI * 5.0 * real'(i) / 64.0));
    run(1'b0);
    fill_random(64, 16000);
    run(1'b1);

    // Reset halfway through pass 1, then a fresh impulse frame
    sel = 1'b0;
    fill_random(8, 4000);
    load_frame(8);
    repeat (8 + 4 - 1) step();
    reset = 1'b1;
    #1 check_reset_vals("reset_compute");
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 8; i++) x[i] = (i == 0) ? 1000 : 0;
    run(1'b0);

    // Reset while bins are streaming out
    fill_random(8, 4000);
    model(8, 1'b0);
    load_frame(8);
    wait_first(8, 3);
    collect(8, 3, 1'b1);
    reset = 1'b1;
    #1 check_reset_vals("reset_output");
    step();
    reset = 1'b0;
    step();
    fill_random(8, 4000);
    run(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_radix2_iter.md
Name: fft_radix2_iter

Overview:
- Parametrised N-point radix-2 decimation-in-time FFT core for the vowel-classifier front end.
- Replaces the fixed 8-point, three-stage unrolled pipeline.
- Loads N real samples serially and runs log2(N) passes through one shared complex butterfly over an in-place working memory.
- Streams N complex bins out in natural order with output back-pressure.

Parameters:
- N, 8: transform length; power of two, 8..512.
- LOG2N, 3: log2(N); must match N.
- Q_IN, 15: input sample MSB index (width Q_IN+1, signed); Q_IN <= Q_OUT.
- Q_DATA, 15: twiddle fraction bits (width Q_DATA+1, signed, +1.0 coded as 2^Q_DATA-1).
- Q_OUT, 15: working/output MSB index (width Q_OUT+1, signed).
- SCALE, 0: 1 = arithmetic shift right by 1 after every pass (result / N); 0 = unscaled with saturation.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  sample strobe
- data_in  in  Q_IN+1  signed real sample
- ready_in  out  1  core accepts samples (IDLE/LOAD)
- valid_out  out  1  bin valid
- ready_out  in  1  downstream accepts bin
- addr_out  out  LOG2N  bin index 0..N-1
- data_out_real  out  Q_OUT+1  bin real part
- data_out_imag  out  Q_OUT+1  bin imaginary part
- last_out  out  1  high with bin N-1

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; all counters = 0.
  - ready_in = 1; valid_out = 0; addr_out = 0; data_out_real = 0; data_out_imag = 0; last_out = 0.
  - Working memory is not cleared.
- States: IDLE -> LOAD -> COMPUTE -> OUTPUT -> IDLE.
- Input handshake:
  - A sample is accepted on any edge with valid_in & ready_in.
  - The first accepted sample moves IDLE -> LOAD.
  - Sample number c is written to address bitrev(c). Real part = sign-extended data_in; imaginary part = 0.
  - When the N-th sample is accepted, go to COMPUTE; ready_in drops on the next cycle.
  - valid_in while ready_in = 0 is ignored and does not corrupt the frame.
- COMPUTE:
  - Pass s = 0..LOG2N-1, butterfly j = 0..N/2-1:
    - half = 2^s
    - a = (j>>s)*2*half + (j & (half-1))
    - b = a + half
    - twiddle index k = (j & (half-1)) << (LOG2N-1-s)
    - W_k = exp(-j*2*pi*k/N)
  - Each butterfly takes 2 cycles: read a, b and W_k into registers, then write both results in place. There is no read/write overlap, so there is no hazard.
  - Pass duration = N cycles; COMPUTE duration = N*LOG2N cycles exactly.
- Butterfly arithmetic:
  - t = W*b. Each product is rounded: add 2^(Q_DATA-1), then arithmetic shift right by Q_DATA.
  - y0 = a + t; y1 = a - t, computed at full width plus 2 guard bits.
  - If SCALE = 1, shift right by 1.
  - Saturate to [-2^Q_OUT, 2^Q_OUT-1].
- OUTPUT:
  - Bins are read in natural order 0..N-1.
  - The first valid_out is asserted exactly N*LOG2N+2 cycles after the edge that accepted the last sample.
  - valid_out, addr_out, data and last_out stay stable while ready_out = 0.
  - The core advances one bin per edge with valid_out & ready_out.
  - After bin N-1 is accepted: valid_out = 0 and last_out = 0 next cycle, state = IDLE, ready_in = 1.
- Reset mid-operation, in any state: return immediately to the reset values. A partial frame is discarded. The next accepted sample is sample 0.

Decomposition:
- Shared package fft_pkg:
  - state encoding (IDLE, LOAD, COMPUTE, OUTPUT)
  - bit-reverse function
  - saturation function
  - default Q constants
- Sub-module fft_twiddle_rom (parameters N, Q_DATA):
  - N/2-entry table of W_k, real and imag, computed at elaboration.
  - Registered read, 1-cycle latency, aligned with the butterfly read cycle.

Test Plan:
- Impulse (N=8, SCALE=0): x = [1000,0,...,0] -> all 8 bins real = 1000, imag = 0; addr_out 0..7; last_out only on bin 7; first valid_out 26 cycles after the last sample.
- DC (N=8, SCALE=0): all samples 1000 -> bin0 = 8000+0j, bins 1..7 = 0 (±1 LSB). Same stimulus with SCALE=1 -> bin0 = 1000.
- Nyquist and saturation (N=8):
  - Alternating +1000/-1000 -> bin4 = 8000, others 0 (±1 LSB).
  - All samples 32767 with SCALE=0 -> bin0 = 32767 (saturated), no wrap.
- Large N (N=64): single cosine at bin 5, amplitude 16384, SCALE=1 -> bins 5 and 59 real ≈ 8192 (±4 LSB), all others |x| <= 4.
- Back-pressure: random ready_out with 50% duty -> bin sequence and values identical to the unstalled run; outputs stable while stalled; valid_in pulses during COMPUTE are ignored.
- Reset mid-COMPUTE: assert reset halfway through pass 1 -> outputs return to reset values immediately; a fresh impulse frame then produces correct bins.
